// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive front end.
// The break-decode feature is enabled by defining PS2_BREAK_DECODE_EN.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;
  localparam int PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_glitch_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter for one PS/2 pin.
// The filtered level only moves after FILTER_LEN consecutive samples disagree with it.
module ps2_glitch_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic filtered
);

  localparam int CW = $clog2(FILTER_LEN) + 1;

  logic       sync_1;
  logic       sync_2;
  logic [CW-1:0] run_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= pin;
      sync_2 <= sync_1;
    end
  end

  // Any sample that agrees with the current level restarts the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt  <= '0;
      filtered <= 1'b1;
    end else if (sync_2 == filtered) begin
      run_cnt <= '0;
    end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
      run_cnt  <= '0;
      filtered <= sync_2;
    end else begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_rx_frontend.sv
// PS/2 device-to-host frame receiver with pin conditioning and a small byte FIFO.
// Define PS2_BREAK_DECODE_EN to fold E0/F0 prefixes into rx_ext/rx_rel flags.
module ps2_rx_frontend
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 32000000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
`ifdef PS2_BREAK_DECODE_EN
  output logic       rx_ext,
  output logic       rx_rel,
`endif
  output logic       busy
);

  localparam logic [63:0] TIMEOUT_CYC = 64'(TIMEOUT_US) * 64'(CLK_HZ) / 64'd1000000;
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TIMEOUT_LOAD = TO_W'(TIMEOUT_CYC);
  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;
`ifdef PS2_BREAK_DECODE_EN
  localparam int ENTRY_W = 10;
`else
  localparam int ENTRY_W = 8;
`endif

  logic clk_f;
  logic data_f;
  logic clk_f_prev;
  logic fall;

  ps2_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk      (clk),
    .reset_n  (reset_n),
    .pin      (ps2_clk),
    .filtered (clk_f)
  );

  ps2_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk      (clk),
    .reset_n  (reset_n),
    .pin      (ps2_data),
    .filtered (data_f)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clk_f_prev <= 1'b1;
    else          clk_f_prev <= clk_f;
  end

  assign fall = clk_f_prev & ~clk_f;

  ps2_state_t         state;
  logic [2:0]         bit_cnt;
  logic [7:0]         shift_reg;
  logic               par_bit;
  logic [TO_W-1:0]    tmr;
  logic               push_req;
  logic [ENTRY_W-1:0] push_data;
  logic               drop;
`ifdef PS2_BREAK_DECODE_EN
  logic               ext_pend;
  logic               rel_pend;
`endif

  assign busy = (state != IDLE);

  // Frame FSM: every decision is taken on a filtered clock fall, except the timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      tmr        <= '0;
      push_req   <= 1'b0;
      push_data  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
      ext_pend   <= 1'b0;
      rel_pend   <= 1'b0;
`endif
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      push_req   <= 1'b0;
      if (fall) begin
        tmr <= TIMEOUT_LOAD;
        case (state)
          IDLE: begin
            if (!data_f) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
              ext_pend  <= 1'b0;
              rel_pend  <= 1'b0;
`endif
            end
          end
          DATA: begin
            shift_reg <= {data_f, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_f;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!data_f) begin
              frame_err <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
              ext_pend  <= 1'b0;
              rel_pend  <= 1'b0;
`endif
            end else if (!(^{shift_reg, par_bit})) begin
              parity_err <= 1'b1;
            end else begin
`ifdef PS2_BREAK_DECODE_EN
              if (shift_reg == PS2_EXT) begin
                ext_pend <= 1'b1;
              end else if (shift_reg == PS2_REL) begin
                rel_pend <= 1'b1;
              end else begin
                push_req  <= 1'b1;
                push_data <= {ext_pend, rel_pend, shift_reg};
                ext_pend  <= 1'b0;
                rel_pend  <= 1'b0;
              end
`else
              push_req  <= 1'b1;
              push_data <= shift_reg;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tmr == '0) begin
          state     <= IDLE;
          frame_err <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
          ext_pend  <= 1'b0;
          rel_pend  <= 1'b0;
`endif
        end else begin
          tmr <= tmr - 1'b1;
        end
      end
`ifdef PS2_BREAK_DECODE_EN
      if (drop) begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end
`endif
    end
  end

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               empty;
  logic               full;
  logic               pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                    (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign rx_valid = ~empty;
  assign pop      = rx_valid & rx_ready;
  assign drop     = push_req & full & ~pop;

`ifdef PS2_BREAK_DECODE_EN
  assign {rx_ext, rx_rel, rx_data} = mem[rd_ptr[IDX_W-1:0]];
`else
  assign rx_data = mem[rd_ptr[IDX_W-1:0]];
`endif

  // A pop frees the full slot in the same cycle, so push-with-pop never overflows.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_req && (!full || pop)) begin
        mem[wr_ptr[IDX_W-1:0]] <= push_data;
        wr_ptr                 <= wr_ptr + 1'b1;
      end
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_rx_frontend.sv
// Directed self-checking bench for ps2_rx_frontend; PS/2 frames are bit-banged on the raw pins.
// Define PS2_BREAK_DECODE_EN for both bench and RTL to exercise prefix folding.
`timescale 1ns/1ps
module tb_ps2_rx_frontend;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;
  logic       busy;
  logic       rx_ext;
  logic       rx_rel;

  int n_cmp = 0;
  int n_mis = 0;
  int pe_cnt = 0;
  int fe_cnt = 0;
  int valid_cyc = 0;
  logic [9:0] rx_q [$];

  ps2_rx_frontend dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow),
`ifdef PS2_BREAK_DECODE_EN
    .rx_ext     (rx_ext),
    .rx_rel     (rx_rel),
`endif
    .busy       (busy)
  );

`ifndef PS2_BREAK_DECODE_EN
  assign rx_ext = 1'b0;
  assign rx_rel = 1'b0;
`endif

  always #15.625 clk = ~clk;

  // Observe the DUT away from the rising edge and log every accepted entry and error pulse.
  always @(negedge clk) begin
    if (parity_err) pe_cnt++;
    if (frame_err) fe_cnt++;
    if (rx_valid) valid_cyc++;
    if (rx_valid && rx_ready) rx_q.push_back({rx_ext, rx_rel, rx_data});
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_rx(input string tag, input logic [9:0] exp);
    if (rx_q.size() == 0) check_output(tag, 32'hDEAD, {22'd0, exp});
    else check_output(tag, {22'd0, rx_q.pop_front()}, {22'd0, exp});
  endtask

  // Drive the first n_bits of an 11-bit frame; data changes only while the PS/2 clock is high.
  task automatic apply_stimulus(input logic [7:0] b, input bit bad_par, input int n_bits,
                                input int half);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < n_bits; i++) begin
      ps2_data = fr[i];
      wait_cycles(half);
      ps2_clk = 1'b0;
      wait_cycles(half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  int pe0, fe0, v0;

  initial begin
    wait_cycles(5);
    check_output("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_output("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check_output("reset_parity_err", {31'd0, parity_err}, 32'd0);
    check_output("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check_output("reset_overflow", {31'd0, overflow}, 32'd0);
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    wait_cycles(20);

    // Valid 0x1C at 12.5 kHz
    pe0 = pe_cnt; fe0 = fe_cnt; v0 = valid_cyc;
    apply_stimulus(8'h1C, 1'b0, 11, 1280);
    wait_cycles(100);
    expect_rx("valid_1c_data", 10'h01C);
    check_output("valid_1c_cycles", valid_cyc - v0, 1);
    check_output("valid_1c_pe", pe_cnt - pe0, 0);
    check_output("valid_1c_fe", fe_cnt - fe0, 0);
    check_output("valid_1c_busy", {31'd0, busy}, 32'd0);

    // Parity error
    pe0 = pe_cnt; fe0 = fe_cnt; v0 = valid_cyc;
    apply_stimulus(8'h1C, 1'b1, 11, 50);
    wait_cycles(50);
    check_output("parity_pe", pe_cnt - pe0, 1);
    check_output("parity_fe", fe_cnt - fe0, 0);
    check_output("parity_no_valid", valid_cyc - v0, 0);

    // Short clock glitches are filtered out
    fe0 = fe_cnt;
    for (int g = 0; g < 3; g++) begin
      ps2_clk = 1'b0;
      wait_cycles(3);
      ps2_clk = 1'b1;
      wait_cycles(20);
    end
    check_output("glitch_fe", fe_cnt - fe0, 0);
    check_output("glitch_busy", {31'd0, busy}, 32'd0);

    // Abort after 4 bits, then let the timeout expire
    apply_stimulus(8'h00, 1'b0, 4, 50);
    wait_cycles(20);
    check_output("abort_busy", {31'd0, busy}, 32'd1);
    wait_cycles(5980);
    check_output("timeout_not_yet", {31'd0, busy}, 32'd1);
    wait_cycles(2000);
    check_output("timeout_fe", fe_cnt - fe0, 1);
    check_output("timeout_busy", {31'd0, busy}, 32'd0);
    apply_stimulus(8'h5A, 1'b0, 11, 50);
    wait_cycles(50);
    expect_rx("after_timeout_5a", 10'h05A);
    check_output("after_timeout_fe", fe_cnt - fe0, 1);

    // Overflow: fill four entries, drop the fifth
    rx_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus(8'(k), 1'b0, 11, 50);
    end
    wait_cycles(20);
    check_output("full_no_overflow", {31'd0, overflow}, 32'd0);
    check_output("full_valid", {31'd0, rx_valid}, 32'd1);
    apply_stimulus(8'h05, 1'b0, 11, 50);
    wait_cycles(20);
    check_output("overflow_set", {31'd0, overflow}, 32'd1);
    rx_ready = 1'b1;
    wait_cycles(10);
    expect_rx("drain_1", 10'h001);
    expect_rx("drain_2", 10'h002);
    expect_rx("drain_3", 10'h003);
    expect_rx("drain_4", 10'h004);
    check_output("drain_empty", {31'd0, rx_valid}, 32'd0);
    check_output("drain_q_empty", rx_q.size(), 0);
    check_output("overflow_sticky", {31'd0, overflow}, 32'd1);

    // Reset in the middle of a frame
    apply_stimulus(8'hFF, 1'b0, 6, 50);
    wait_cycles(20);
    check_output("midframe_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #2;
    check_output("midreset_busy", {31'd0, busy}, 32'd0);
    check_output("midreset_overflow", {31'd0, overflow}, 32'd0);
    check_output("midreset_valid", {31'd0, rx_valid}, 32'd0);
    check_output("midreset_errs", {30'd0, parity_err, frame_err}, 32'd0);
    wait_cycles(5);
    reset_n = 1'b1;
    wait_cycles(20);
    apply_stimulus(8'h29, 1'b0, 11, 50);
    wait_cycles(50);
    expect_rx("after_reset_29", 10'h029);

`ifdef PS2_BREAK_DECODE_EN
    apply_stimulus(8'hE0, 1'b0, 11, 50);
    apply_stimulus(8'hF0, 1'b0, 11, 50);
    apply_stimulus(8'h75, 1'b0, 11, 50);
    wait_cycles(50);
    expect_rx("break_ext_rel_75", 10'h375);
    check_output("break_single_entry", rx_q.size(), 0);
    apply_stimulus(8'h75, 1'b0, 11, 50);
    wait_cycles(50);
    expect_rx("make_75", 10'h075);
`endif

    check_output("final_q_empty", rx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
